// File: rtl/frame_geometry_cfg_pkg.sv
// Shared LCD panel IDs, camera geometry table and FSM encoding for frame_geometry_cfg.
// The LCD driver imports the same constants so both sides agree on one table.
package frame_geometry_cfg_pkg;

   localparam int TABLE_W = 12;

   localparam logic [15:0] LCD_ID_4342 = 16'h4342;
   localparam logic [15:0] LCD_ID_7084 = 16'h7084;
   localparam logic [15:0] LCD_ID_7016 = 16'h7016;
   localparam logic [15:0] LCD_ID_1018 = 16'h1018;
   localparam logic [15:0] LCD_ID_4384 = 16'h4384;

   typedef struct packed {
      logic [TABLE_W-1:0] h;
      logic [TABLE_W-1:0] v;
      logic [TABLE_W-1:0] hts;
      logic [TABLE_W-1:0] vts;
      logic               known;
   } geom_t;

   localparam geom_t GEOM_DEFAULT = '{h: 12'd800,  v: 12'd480, hts: 12'd1800, vts: 12'd1000, known: 1'b0};
   localparam geom_t GEOM_4342    = '{h: 12'd480,  v: 12'd272, hts: 12'd1800, vts: 12'd1000, known: 1'b1};
   localparam geom_t GEOM_7084    = '{h: 12'd800,  v: 12'd480, hts: 12'd1800, vts: 12'd1000, known: 1'b1};
   localparam geom_t GEOM_7016    = '{h: 12'd1024, v: 12'd600, hts: 12'd2200, vts: 12'd1000, known: 1'b1};
   localparam geom_t GEOM_1018    = '{h: 12'd1280, v: 12'd800, hts: 12'd2570, vts: 12'd980,  known: 1'b1};
   localparam geom_t GEOM_4384    = '{h: 12'd800,  v: 12'd480, hts: 12'd1800, vts: 12'd1000, known: 1'b1};

   typedef enum logic [2:0] {
      ST_STABLE,
      ST_LOOKUP,
      ST_MUL,
      ST_ROUND,
      ST_REQ,
      ST_RUN
   } state_t;

   function automatic geom_t lookup_geom(input logic [15:0] id);
      case (id)
         LCD_ID_4342: return GEOM_4342;
         LCD_ID_7084: return GEOM_7084;
         LCD_ID_7016: return GEOM_7016;
         LCD_ID_1018: return GEOM_1018;
         LCD_ID_4384: return GEOM_4384;
         default:     return GEOM_DEFAULT;
      endcase
   endfunction

endpackage

// File: rtl/frame_geometry_cfg_serial_mult.sv
// Serial shift-add multiplier: one partial product per cycle, W cycles after start.
// done is high during the final accumulation cycle, so p is complete on the next cycle.
module serial_mult #(
   parameter int W = 13
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p
);

   localparam int CW = $clog2(W + 1);

   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  step;

   // NOTE: non-blocking assignments so every register updates from its pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         step   <= '0;
         busy   <= 1'b0;
         p      <= '0;
      end else if (start) begin
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         step   <= '0;
         busy   <= 1'b1;
         p      <= '0;
      end else if (busy) begin
         if (mplier[0]) p <= p + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         step   <= step + 1'b1;
         if (step == CW'(W - 1)) busy <= 1'b0;
      end
   end

   assign done = busy && (step == CW'(W - 1));

endmodule

// File: rtl/frame_geometry_cfg.sv
// Debounces the panel ID and binning mode, looks up camera geometry, computes the
// burst-rounded SDRAM frame size and publishes the whole set through a req/ack handshake.
module frame_geometry_cfg
   import frame_geometry_cfg_pkg::*;
#(
   parameter int PIX_W         = 13,
   parameter int ADDR_W        = 24,
   parameter int STABLE_CYCLES = 16,
   parameter int BURST_LEN     = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       lcd_id,
   input  logic              bin_en,
   input  logic              cfg_ack,
   output logic [PIX_W-1:0]  cmos_h_pixel,
   output logic [PIX_W-1:0]  cmos_v_pixel,
   output logic [PIX_W-1:0]  total_h_pixel,
   output logic [PIX_W-1:0]  total_v_pixel,
   output logic [ADDR_W-1:0] sdram_max_addr,
   output logic              id_known,
   output logic              cfg_req,
   output logic              cfg_valid
);

   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int PROD_W = 2 * PIX_W;
   localparam int WIDE   = (PROD_W + 1 > ADDR_W + 1) ? PROD_W + 1 : ADDR_W + 1;

   localparam logic [WIDE-1:0] ROUND_ADD = WIDE'(BURST_LEN - 1);
   localparam logic [WIDE-1:0] ADDR_MAX  = WIDE'({ADDR_W{1'b1}});
   localparam logic [WIDE-1:0] ADDR_SAT  = ADDR_MAX - ROUND_ADD;

   state_t            state, state_next;
   logic [16:0]       cur, sample;
   logic              change;
   logic [CNT_W-1:0]  stable_cnt;
   logic              cnt_full;
   logic              publish;

   geom_t             tbl;
   logic [PIX_W-1:0]  tbl_h, tbl_v;
   logic [PIX_W-1:0]  sh_h, sh_v, sh_hts, sh_vts;
   logic              sh_known;

   logic              mult_start, mult_busy, mult_done;
   logic [PROD_W-1:0] product;
   logic [WIDE-1:0]   sum, rounded;
   logic [ADDR_W-1:0] addr_next;

   assign cur      = {lcd_id, bin_en};
   assign change   = (cur != sample);
   assign cnt_full = (stable_cnt == CNT_W'(STABLE_CYCLES));

   assign tbl   = lookup_geom(lcd_id);
   assign tbl_h = bin_en ? PIX_W'(tbl.h >> 1) : PIX_W'(tbl.h);
   assign tbl_v = bin_en ? PIX_W'(tbl.v >> 1) : PIX_W'(tbl.v);

   serial_mult #(.W(PIX_W)) u_mult (
      .clk   (clk),
      .rst   (rst),
      .start (mult_start),
      .a     (tbl_h),
      .b     (tbl_v),
      .busy  (mult_busy),
      .done  (mult_done),
      .p     (product)
   );

   // Round up to a whole burst; anything past the address space pins to the last burst.
   assign sum       = WIDE'(product) + ROUND_ADD;
   assign rounded   = sum & ~ROUND_ADD;
   assign addr_next = (rounded > ADDR_MAX) ? ADDR_W'(ADDR_SAT) : ADDR_W'(rounded);

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
      state_next = state;
      mult_start = 1'b0;
      case (state)
         ST_STABLE: if (cnt_full) state_next = ST_LOOKUP;
         ST_LOOKUP: begin
            mult_start = 1'b1;
            state_next = ST_MUL;
         end
         ST_MUL: begin
            if (mult_done)      state_next = ST_ROUND;
            else if (!mult_busy) state_next = ST_STABLE;
         end
         ST_ROUND:  state_next = ST_REQ;
         ST_REQ:    if (cfg_ack) state_next = ST_RUN;
         ST_RUN:    state_next = ST_RUN;
         default:   state_next = ST_STABLE;
      endcase
      // An input change always restarts debounce, even against a same-cycle ack.
      if (change) state_next = ST_STABLE;
   end

   assign publish = (state == ST_ROUND) && !change;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_STABLE;
         sample         <= '0;
         stable_cnt     <= '0;
         cfg_req        <= 1'b0;
         cfg_valid      <= 1'b0;
         cmos_h_pixel   <= '0;
         cmos_v_pixel   <= '0;
         total_h_pixel  <= '0;
         total_v_pixel  <= '0;
         sdram_max_addr <= '0;
         id_known       <= 1'b0;
      end else begin
         state     <= state_next;
         sample    <= cur;
         cfg_req   <= (state_next == ST_REQ);
         cfg_valid <= (state_next == ST_RUN);
         if (change)         stable_cnt <= '0;
         else if (!cnt_full) stable_cnt <= stable_cnt + 1'b1;
         if (publish) begin
            cmos_h_pixel   <= sh_h;
            cmos_v_pixel   <= sh_v;
            total_h_pixel  <= sh_hts;
            total_v_pixel  <= sh_vts;
            id_known       <= sh_known;
            sdram_max_addr <= addr_next;
         end
      end
   end

   // NOTE: shadow regs are not reset; LOOKUP always writes them before anything reads them.
   always_ff @(posedge clk) begin
      if (state == ST_LOOKUP) begin
         sh_h     <= tbl_h;
         sh_v     <= tbl_v;
         sh_hts   <= PIX_W'(tbl.hts);
         sh_vts   <= PIX_W'(tbl.vts);
         sh_known <= tbl.known;
      end
   end

endmodule

// File: tb/tb_frame_geometry_cfg.sv
// Self-checking bench: timeline model of debounce/request/run plus directed and random stimulus.
module tb_frame_geometry_cfg;

   localparam int PIX_W         = 13;
   localparam int ADDR_W        = 24;
   localparam int STABLE_CYCLES = 16;
   localparam int BURST_LEN     = 256;
   localparam int LAT           = STABLE_CYCLES + PIX_W + 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       lcd_id;
   logic              bin_en;
   logic              cfg_ack;
   logic [PIX_W-1:0]  cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel;
   logic [ADDR_W-1:0] sdram_max_addr;
   logic              id_known, cfg_req, cfg_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_geometry_cfg #(
      .PIX_W(PIX_W), .ADDR_W(ADDR_W), .STABLE_CYCLES(STABLE_CYCLES), .BURST_LEN(BURST_LEN)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .lcd_id         (lcd_id),
      .bin_en         (bin_en),
      .cfg_ack        (cfg_ack),
      .cmos_h_pixel   (cmos_h_pixel),
      .cmos_v_pixel   (cmos_v_pixel),
      .total_h_pixel  (total_h_pixel),
      .total_v_pixel  (total_v_pixel),
      .sdram_max_addr (sdram_max_addr),
      .id_known       (id_known),
      .cfg_req        (cfg_req),
      .cfg_valid      (cfg_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_REQ, M_RUN} mode_t;
   mode_t       mode = M_IDLE;
   int          edge_n = 0, last_change = 0;
   logic [16:0] prev = '0;
   bit          model_ready = 0;
   int          exp_h = 0, exp_v = 0, exp_hts = 0, exp_vts = 0, exp_known = 0, exp_addr = 0;

   function automatic void ref_geom(input logic [15:0] id, input logic bin,
                                    output int h, output int v, output int hts,
                                    output int vts, output int known, output int addr);
      longint prod, r;
      case (id)
         16'h4342:          begin h = 480;  v = 272; hts = 1800; vts = 1000; known = 1; end
         16'h7084, 16'h4384: begin h = 800;  v = 480; hts = 1800; vts = 1000; known = 1; end
         16'h7016:          begin h = 1024; v = 600; hts = 2200; vts = 1000; known = 1; end
         16'h1018:          begin h = 1280; v = 800; hts = 2570; vts = 980;  known = 1; end
         default:           begin h = 800;  v = 480; hts = 1800; vts = 1000; known = 0; end
      endcase
      if (bin) begin
         h = h / 2;
         v = v / 2;
      end
      prod = longint'(h) * longint'(v);
      r = ((prod + BURST_LEN - 1) / BURST_LEN) * BURST_LEN;
      if (r > (longint'(1) << ADDR_W) - 1) r = (longint'(1) << ADDR_W) - BURST_LEN;
      addr = int'(r);
   endfunction

   // Request appears LAT edges after the last input change; ack moves it to run.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         prev = '0;
         last_change = edge_n;
         mode = M_IDLE;
         exp_h = 0; exp_v = 0; exp_hts = 0; exp_vts = 0; exp_known = 0; exp_addr = 0;
         model_ready = 1;
      end else begin
         if ({lcd_id, bin_en} != prev) begin
            last_change = edge_n;
            mode = M_IDLE;
         end else if (mode == M_REQ) begin
            if (cfg_ack) mode = M_RUN;
         end else if (mode == M_IDLE && edge_n - last_change == LAT) begin
            mode = M_REQ;
            ref_geom(lcd_id, bin_en, exp_h, exp_v, exp_hts, exp_vts, exp_known, exp_addr);
         end
         prev = {lcd_id, bin_en};
      end
      edge_n++;
   end

   int   req_rises = 0;
   logic req_last = 1'b0;

   initial forever begin
      @(negedge clk);
      if (model_ready) begin
         check("cyc_cfg_req",   cfg_req,        (mode == M_REQ));
         check("cyc_cfg_valid", cfg_valid,      (mode == M_RUN));
         check("cyc_h",         cmos_h_pixel,   exp_h);
         check("cyc_v",         cmos_v_pixel,   exp_v);
         check("cyc_hts",       total_h_pixel,  exp_hts);
         check("cyc_vts",       total_v_pixel,  exp_vts);
         check("cyc_known",     id_known,       exp_known);
         check("cyc_addr",      sdram_max_addr, exp_addr);
         if (cfg_req === 1'b1 && req_last !== 1'b1) req_rises++;
         req_last = cfg_req;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply(input logic [15:0] id, input logic b);
      lcd_id = id;
      bin_en = b;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (cfg_req !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_latency"}, n, LAT);
   endtask

   task automatic do_ack(input string name);
      cfg_ack = 1'b1;
      @(posedge clk);
      #1;
      cfg_ack = 1'b0;
      check({name, "_valid"}, cfg_valid, 1);
      check({name, "_req_low"}, cfg_req, 0);
   endtask

   task automatic check_set(input string name, input int h, input int v, input int hts,
                            input int vts, input int known, input int addr);
      check({name, "_h"},     cmos_h_pixel,   h);
      check({name, "_v"},     cmos_v_pixel,   v);
      check({name, "_hts"},   total_h_pixel,  hts);
      check({name, "_vts"},   total_v_pixel,  vts);
      check({name, "_known"}, id_known,       known);
      check({name, "_addr"},  sdram_max_addr, addr);
      check({name, "_model_addr"}, exp_addr,  addr);
   endtask

   logic [15:0] ids [5] = '{16'h4342, 16'h7084, 16'h7016, 16'h1018, 16'h4384};

   initial begin
      int r0;
      rst = 1'b1;
      lcd_id = 16'h0;
      bin_en = 1'b0;
      cfg_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", cfg_req, 0);
      check("rst_valid", cfg_valid, 0);
      check("rst_h", cmos_h_pixel, 0);
      check("rst_addr", sdram_max_addr, 0);
      check("rst_known", id_known, 0);
      rst = 1'b0;

      apply(16'h4342, 1'b0);
      wait_req("id4342");
      check_set("id4342", 480, 272, 1800, 1000, 1, 130560);
      do_ack("id4342");

      apply(16'h4342, 1'b1);
      check("bin_change_valid", cfg_valid, 0);
      check("bin_change_held_h", cmos_h_pixel, 480);
      wait_req("bin4342");
      check_set("bin4342", 240, 136, 1800, 1000, 1, 32768);
      do_ack("bin4342");

      apply(16'h1018, 1'b0);
      wait_req("id1018");
      check_set("id1018", 1280, 800, 2570, 980, 1, 1024000);
      do_ack("id1018");

      apply(16'hBEEF, 1'b0);
      wait_req("idbeef");
      check_set("idbeef", 800, 480, 1800, 1000, 0, 384000);
      do_ack("idbeef");

      r0 = req_rises;
      for (int i = 0; i < 20; i++) begin
         lcd_id = (i % 2 == 0) ? 16'h7016 : 16'h7084;
         repeat (5) @(posedge clk);
         #1;
      end
      apply(16'h7016, 1'b0);
      wait_req("toggle");
      check_set("toggle", 1024, 600, 2200, 1000, 1, 614400);
      do_ack("toggle");
      repeat (40) @(posedge clk);
      #1;
      check("toggle_one_req", req_rises - r0, 1);

      apply(16'h7084, 1'b0);
      check("run_change_valid", cfg_valid, 0);
      check("run_change_held_h", cmos_h_pixel, 1024);
      check("run_change_held_addr", sdram_max_addr, 614400);
      wait_req("id7084");
      check_set("id7084", 800, 480, 1800, 1000, 1, 384000);

      cfg_ack = 1'b1;
      apply(16'h4342, 1'b0);
      cfg_ack = 1'b0;
      check("ack_change_req", cfg_req, 0);
      check("ack_change_valid", cfg_valid, 0);
      wait_req("after_ack_change");
      check_set("after_ack_change", 480, 272, 1800, 1000, 1, 130560);
      do_ack("after_ack_change");

      apply(16'h1018, 1'b0);
      repeat (24) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mulrst_req", cfg_req, 0);
      check("mulrst_valid", cfg_valid, 0);
      check("mulrst_h", cmos_h_pixel, 0);
      check("mulrst_vts", total_v_pixel, 0);
      check("mulrst_addr", sdram_max_addr, 0);
      @(posedge clk);
      #1;
      wait_req("after_rst");
      check_set("after_rst", 1280, 800, 2570, 980, 1, 1024000);
      do_ack("after_rst");

      for (int ph = 0; ph < 250; ph++) begin
         int idx = $urandom_range(0, 5);
         int hold = $urandom_range(1, 45);
         lcd_id = (idx == 5) ? 16'($urandom) : ids[idx];
         bin_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
         for (int c = 0; c < hold; c++) begin
            cfg_ack = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
         end
      end
      cfg_ack = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
